// File: rtl/isp_luma_stat.sv
`default_nettype none
// ============================================================================
// Module   : isp_luma_stat
// Purpose  : Luma statistics tap on a DVP video stream. The video is passed
//            through with exactly one pclk of latency. Per frame it
//            accumulates the luma sum, the pixel count, and the counts of
//            under- and over-exposed pixels. It also checks the frame
//            geometry against WIDTH x HEIGHT. The results are published on
//            the following frame start, together with a one-cycle stat_done
//            pulse.
// Ports    : pclk, rst                    - clock / sync active-high reset
//            in_href, in_vsync, in_data   - DVP input stream
//            out_href, out_vsync, out_data- 1-cycle delayed passthrough
//            thresh_lo, thresh_hi         - exposure thresholds (strict)
//            win_x0/x1/y0/y1              - inclusive ROI bounds
//            stat_sum/pix/lo/hi, stat_err - last completed frame results
//            stat_done                    - 1-cycle pulse on result update
// Config   : `define ISP_LUMA_STAT_WINDOW_EN restricts accumulation to the
//            ROI. When it is undefined, every pixel is accumulated and the
//            win_* inputs are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module isp_luma_stat #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             in_href,
  input  logic             in_vsync,
  input  logic [BITS-1:0]  in_data,
  output logic             out_href,
  output logic             out_vsync,
  output logic [BITS-1:0]  out_data,
  input  logic [BITS-1:0]  thresh_lo,
  input  logic [BITS-1:0]  thresh_hi,
  input  logic [11:0]      win_x0,
  input  logic [11:0]      win_x1,
  input  logic [11:0]      win_y0,
  input  logic [11:0]      win_y1,
  output logic [BITS+19:0] stat_sum,
  output logic [19:0]      stat_pix,
  output logic [19:0]      stat_lo,
  output logic [19:0]      stat_hi,
  output logic             stat_done,
  output logic             stat_err
);

  localparam int          SUM_W    = BITS + 20;
  localparam logic [11:0] GEO_MAX  = 12'hFFF;
  localparam logic [19:0] CNT_MAX  = 20'hFFFFF;
  localparam logic [11:0] WIDTH_C  = 12'(WIDTH);
  localparam logic [11:0] HEIGHT_C = 12'(HEIGHT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [11:0]      col;
  logic [11:0]      row;
  logic             line_err;
  logic [SUM_W-1:0] acc_sum;
  logic [19:0]      acc_pix;
  logic [19:0]      acc_lo;
  logic [19:0]      acc_hi;

  logic             frame_start;
  logic             href_fall;
  logic             col_bad;
  logic [11:0]      rows_total;
  logic             frame_err;
  logic             in_win;
  logic             take;
  logic [SUM_W-1:0] base_sum;
  logic [19:0]      base_pix;
  logic [19:0]      base_lo;
  logic [19:0]      base_hi;
  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sum_next;
  logic [19:0]      pix_next;
  logic [19:0]      lo_next;
  logic [19:0]      hi_next;

  function automatic logic [19:0] sat_inc20(input logic [19:0] v);
    return (v == CNT_MAX) ? v : v + 20'd1;
  endfunction

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == GEO_MAX) ? v : v + 12'd1;
  endfunction

`ifdef ISP_LUMA_STAT_WINDOW_EN
  // A pixel arriving together with a frame start already belongs to row 0
  // of the new frame, even though the row register is cleared on this edge.
  logic [11:0] row_eff;
  assign row_eff = frame_start ? 12'd0 : row;
`else
  logic unused_win;
  assign unused_win = ^{win_x0, win_x1, win_y0, win_y1};
`endif

  always_comb begin
    // The registered passthrough copies double as the previous-cycle
    // samples for edge detection.
    frame_start = in_vsync & ~out_vsync;
    href_fall   = out_href & ~in_href;
    col_bad     = (col != WIDTH_C);

    // A line that ends on the frame-start cycle still belongs to the frame
    // that is being closed, so it is folded into the geometry verdict.
    rows_total  = href_fall ? sat_inc12(row) : row;
    frame_err   = (rows_total != HEIGHT_C) | line_err | (href_fall & col_bad);

`ifdef ISP_LUMA_STAT_WINDOW_EN
    in_win = (col >= win_x0) && (col <= win_x1) &&
             (row_eff >= win_y0) && (row_eff <= win_y1);
`else
    in_win = 1'b1;
`endif

    take = in_href & in_win & ((state == RUN) | frame_start);

    // On a frame start the accumulators restart from zero, and a coincident
    // pixel is the first contribution to the new frame.
    base_sum = frame_start ? '0 : acc_sum;
    base_pix = frame_start ? '0 : acc_pix;
    base_lo  = frame_start ? '0 : acc_lo;
    base_hi  = frame_start ? '0 : acc_hi;

    sum_ext  = {1'b0, base_sum} + {{(SUM_W + 1 - BITS){1'b0}}, in_data};
    sum_next = base_sum;
    pix_next = base_pix;
    lo_next  = base_lo;
    hi_next  = base_hi;
    if (take) begin
      sum_next = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      pix_next = sat_inc20(base_pix);
      if (in_data < thresh_lo) lo_next = sat_inc20(base_lo);
      if (in_data > thresh_hi) hi_next = sat_inc20(base_hi);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= IDLE;
      out_href  <= 1'b0;
      out_vsync <= 1'b0;
      out_data  <= '0;
      col       <= '0;
      row       <= '0;
      line_err  <= 1'b0;
      acc_sum   <= '0;
      acc_pix   <= '0;
      acc_lo    <= '0;
      acc_hi    <= '0;
      stat_sum  <= '0;
      stat_pix  <= '0;
      stat_lo   <= '0;
      stat_hi   <= '0;
      stat_done <= 1'b0;
      stat_err  <= 1'b0;
    end else begin
      out_href  <= in_href;
      out_vsync <= in_vsync;
      out_data  <= in_data;

      if (in_href) begin
        col <= sat_inc12(col);
      end else if (href_fall) begin
        col <= '0;
      end

      if (frame_start) begin
        row <= '0;
      end else if (href_fall) begin
        row <= sat_inc12(row);
      end

      if (frame_start) begin
        line_err <= 1'b0;
      end else if (href_fall && col_bad) begin
        line_err <= 1'b1;
      end

      acc_sum   <= sum_next;
      acc_pix   <= pix_next;
      acc_lo    <= lo_next;
      acc_hi    <= hi_next;
      stat_done <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_start) state <= RUN;
        end
        RUN: begin
          if (frame_start) begin
            stat_sum  <= acc_sum;
            stat_pix  <= acc_pix;
            stat_lo   <= acc_lo;
            stat_hi   <= acc_hi;
            stat_err  <= frame_err;
            stat_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_isp_luma_stat.sv
`default_nettype none
// ============================================================================
// Module   : tb_isp_luma_stat
// Purpose  : Self-checking bench for isp_luma_stat on a reduced 16x8 frame.
//            Each frame is built as an image (a list of lines of pixels).
//            Its expected statistics are computed directly from that image,
//            and the image is then serialized into DVP cycles. A concurrent
//            monitor checks the one-cycle passthrough and counts stat_done
//            pulses.
// Config   : honours `define ISP_LUMA_STAT_WINDOW_EN (fixed 0..9 x 0..9 ROI)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_isp_luma_stat;
  localparam int BITS = 8;
  localparam int W    = 16;
  localparam int H    = 8;

  logic             pclk = 1'b0;
  logic             rst;
  logic             in_href;
  logic             in_vsync;
  logic [BITS-1:0]  in_data;
  logic             out_href;
  logic             out_vsync;
  logic [BITS-1:0]  out_data;
  logic [BITS-1:0]  thresh_lo;
  logic [BITS-1:0]  thresh_hi;
  logic [11:0]      win_x0;
  logic [11:0]      win_x1;
  logic [11:0]      win_y0;
  logic [11:0]      win_y1;
  logic [BITS+19:0] stat_sum;
  logic [19:0]      stat_pix;
  logic [19:0]      stat_lo;
  logic [19:0]      stat_hi;
  logic             stat_done;
  logic             stat_err;

  always #5 pclk = ~pclk;

  isp_luma_stat #(.BITS(BITS), .WIDTH(W), .HEIGHT(H)) dut (
    .pclk(pclk), .rst(rst),
    .in_href(in_href), .in_vsync(in_vsync), .in_data(in_data),
    .out_href(out_href), .out_vsync(out_vsync), .out_data(out_data),
    .thresh_lo(thresh_lo), .thresh_hi(thresh_hi),
    .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .stat_sum(stat_sum), .stat_pix(stat_pix), .stat_lo(stat_lo),
    .stat_hi(stat_hi), .stat_done(stat_done), .stat_err(stat_err)
  );

  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;
  int done_exp  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Passthrough reference: what the inputs were at the last rising edge.
  logic            exp_h;
  logic            exp_v;
  logic [BITS-1:0] exp_d;
  bit              pt_on = 1'b0;

  always @(posedge pclk) begin
    exp_h <= rst ? 1'b0 : in_href;
    exp_v <= rst ? 1'b0 : in_vsync;
    exp_d <= rst ? '0   : in_data;
    pt_on <= 1'b1;
  end

  always @(negedge pclk) begin
    if (pt_on) begin
      check("passthrough", {out_href, out_vsync, out_data}, {exp_h, exp_v, exp_d});
      if (stat_done === 1'b1) done_seen++;
    end
  end

  // Frame image and reference state.
  logic [BITS-1:0]  img [H][W];
  int               len [H];
  int               nl;
  bit               m_run;
  logic [BITS+19:0] p_sum;
  logic [19:0]      p_pix, p_lo, p_hi;
  logic             p_err;

  // pattern 0: constant cval, 1: alternating 10/250, 2: random
  task automatic fill(input int pattern, input int nlines, input int short_line, input int cval);
    nl = nlines;
    for (int r = 0; r < H; r++) begin
      len[r] = (r == short_line) ? W - 1 : W;
      for (int c = 0; c < W; c++) begin
        case (pattern)
          0:       img[r][c] = BITS'(cval);
          1:       img[r][c] = (c % 2 == 0) ? BITS'(10) : BITS'(250);
          default: img[r][c] = BITS'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  task automatic run_frame(input bit coincide, input int abort_line);
    logic [BITS+19:0] s;
    logic [19:0]      np, nlo, nhi;
    logic             ne;
    bit               exp_rep;
    bit               inwin;
    int               ai;
    bit               qh[$];
    bit               qv[$];
    logic [BITS-1:0]  qd[$];

    s = '0; np = '0; nlo = '0; nhi = '0;
    for (int r = 0; r < nl; r++) begin
      for (int c = 0; c < len[r]; c++) begin
        inwin = 1'b1;
`ifdef ISP_LUMA_STAT_WINDOW_EN
        inwin = (c >= win_x0) && (c <= win_x1) && (r >= win_y0) && (r <= win_y1);
`endif
        if (inwin) begin
          s += (BITS+20)'(img[r][c]);
          np++;
          if (img[r][c] < thresh_lo) nlo++;
          if (img[r][c] > thresh_hi) nhi++;
        end
      end
    end
    ne = (nl != H);
    for (int r = 0; r < nl; r++) if (len[r] != W) ne = 1'b1;

    ai = -1;
    if (!coincide) repeat (4) begin qh.push_back(0); qv.push_back(0); qd.push_back('0); end
    for (int r = 0; r < nl; r++) begin
      for (int c = 0; c < len[r]; c++) begin
        if (r == abort_line && c == 5) ai = qh.size();
        qh.push_back(1); qv.push_back(0); qd.push_back(img[r][c]);
      end
      repeat (3) begin qh.push_back(0); qv.push_back(0); qd.push_back('0); end
    end
    repeat (4) begin qh.push_back(0); qv.push_back(0); qd.push_back('0); end
    qv[0] = 1'b1;
    qv[1] = 1'b1;

    exp_rep = m_run;
    for (int i = 0; i < qh.size(); i++) begin
      @(negedge pclk);
      if (i == 1) begin
        if (exp_rep) begin
          check("report_done", stat_done, 1);
          check("stat_sum", stat_sum, p_sum);
          check("stat_pix", stat_pix, p_pix);
          check("stat_lo", stat_lo, p_lo);
          check("stat_hi", stat_hi, p_hi);
          check("stat_err", stat_err, p_err);
        end else begin
          check("early_done", stat_done, 0);
        end
      end
      if (i == 2) check("done_pulse_width", stat_done, 0);
      if (ai >= 0 && i == ai + 1) begin
        check("rst_outputs", {out_href, out_vsync, out_data}, 0);
        check("rst_stats", {stat_sum, stat_pix, stat_lo, stat_hi}, 0);
        check("rst_flags", {stat_done, stat_err}, 0);
      end
      rst      = (i == ai);
      in_href  = qh[i];
      in_vsync = qv[i];
      in_data  = qd[i];
    end
    if (exp_rep) done_exp++;
    if (ai >= 0) begin
      m_run = 1'b0;
    end else begin
      m_run = 1'b1;
      p_sum = s; p_pix = np; p_lo = nlo; p_hi = nhi; p_err = ne;
    end
  endtask

  task automatic rand_thresh();
    thresh_lo = BITS'($urandom_range(0, 127));
    thresh_hi = BITS'($urandom_range(128, 255));
  endtask

  initial begin
    rst = 1'b1; in_href = 1'b0; in_vsync = 1'b0; in_data = '0;
    thresh_lo = 8'd16; thresh_hi = 8'd235;
`ifdef ISP_LUMA_STAT_WINDOW_EN
    win_x0 = 12'd0; win_x1 = 12'd9; win_y0 = 12'd0; win_y1 = 12'd9;
`else
    win_x0 = 12'($urandom_range(0, 4095)); win_x1 = 12'($urandom_range(0, 4095));
    win_y0 = 12'($urandom_range(0, 4095)); win_y1 = 12'($urandom_range(0, 4095));
`endif
    m_run = 1'b0;
    p_sum = '0; p_pix = '0; p_lo = '0; p_hi = '0; p_err = 1'b0;

    repeat (3) @(negedge pclk);
    check("reset_out_href", out_href, 0);
    check("reset_out_vsync", out_vsync, 0);
    check("reset_out_data", out_data, 0);
    check("reset_stat_sum", stat_sum, 0);
    check("reset_stat_pix", stat_pix, 0);
    check("reset_stat_lo", stat_lo, 0);
    check("reset_stat_hi", stat_hi, 0);
    check("reset_stat_done", stat_done, 0);
    check("reset_stat_err", stat_err, 0);
    rst = 1'b0;

    // Two constant frames: the first starts the FSM, the second reports it.
    fill(0, H, -1, 100); run_frame(1'b0, -1);
    fill(0, H, -1, 100); run_frame(1'b0, -1);
    // Alternating under/over-exposed pixels.
    fill(1, H, -1, 0);   run_frame(1'b0, -1);
    // Random content with random thresholds.
    rand_thresh(); fill(2, H, -1, 0);     run_frame(1'b0, -1);
    // One line missing, then one short line.
    rand_thresh(); fill(2, H - 1, -1, 0); run_frame(1'b0, -1);
    rand_thresh(); fill(2, H, 2, 0);      run_frame(1'b0, -1);
    // Good frame whose first pixel coincides with the frame start.
    rand_thresh(); fill(2, H, -1, 0);     run_frame(1'b1, -1);
    // Reset in the middle of line 3; the partial frame is discarded.
    rand_thresh(); fill(2, H, -1, 0);     run_frame(1'b0, 3);
    rand_thresh(); fill(2, H, -1, 0);     run_frame(1'b0, -1);
    rand_thresh(); fill(2, H, -1, 0);     run_frame(1'b1, -1);
    rand_thresh(); fill(2, H, -1, 0);     run_frame(1'b0, -1);

    repeat (5) @(negedge pclk);
    check("done_count", done_seen, done_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/isp_luma_stat.md
ISP_LUMA_STAT -- requirements
Module: isp_luma_stat

Interface
REQ-001 SHALL have parameter BITS, default 8, pixel width.
REQ-002 SHALL have parameter WIDTH, default 1280, active pixels per line.
REQ-003 SHALL have parameter HEIGHT, default 720, active lines per frame.
REQ-004 SHALL have port pclk  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports in_href, in_vsync  input  1 each  DVP line-valid and frame-sync from the 2D NR output.
REQ-007 SHALL have port in_data  input  BITS  pixel, valid when in_href=1.
REQ-008 SHALL have ports out_href, out_vsync  output  1 each, and out_data  output  BITS  video passthrough.
REQ-009 SHALL have ports thresh_lo, thresh_hi  input  BITS  under- and over-exposure thresholds.
REQ-010 SHALL have ports win_x0, win_x1, win_y0, win_y1  input  12 each  inclusive ROI bounds.
REQ-011 SHALL have port stat_sum  output  BITS+20  luma sum of the last completed frame.
REQ-012 SHALL have ports stat_pix, stat_lo, stat_hi  output  20 each  counts of accumulated pixels, pixels < thresh_lo, and pixels > thresh_hi.
REQ-013 SHALL have port stat_done  output  1  one-cycle pulse when stat_* update.
REQ-014 SHALL have port stat_err  output  1  last frame geometry mismatch.

Function
REQ-015 SHALL register in_href/in_vsync/in_data once: out_* = in_* delayed exactly 1 pclk, data unmodified.
REQ-016 SHALL detect frame start as an in_vsync 0->1 transition between consecutive cycles.
REQ-017 SHALL use a two-state FSM: IDLE after reset; IDLE->RUN on first frame start; RUN stays RUN until reset.
REQ-018 SHALL, in IDLE, ignore pixels and hold stat_done=0.
REQ-019 SHALL, in RUN, add every in_href=1 pixel to sum and pix count; increment lo if in_data<thresh_lo and hi if in_data>thresh_hi (strict compares).
REQ-020 SHALL, on frame start in RUN: copy accumulators to stat_*, assert stat_done the next cycle for 1 cycle, clear accumulators.
REQ-021 SHALL accumulate an in_href=1 pixel coinciding with the frame-start cycle into the new (cleared) frame.
REQ-022 SHALL keep column counter (+1 per href pixel, 0 on href 1->0) and row counter (+1 on href 1->0, 0 on frame start).
REQ-023 SHALL set stat_err at latch time when the completed frame's row count != HEIGHT or any line had column count != WIDTH; otherwise clear it.
REQ-024 SHALL saturate column/row counters at 4095 and pix/lo/hi counters at 2^20-1 (no wrap).
REQ-025 SHALL keep stat_* stable between stat_done pulses; thresholds and window sampled per pixel, changes take effect immediately.

Reset
REQ-026 SHALL, when rst=1 at a pclk edge, set FSM=IDLE, clear all accumulators and counters, and drive out_href=0, out_vsync=0, out_data=0, stat_sum=0, stat_pix=0, stat_lo=0, stat_hi=0, stat_done=0, stat_err=0.
REQ-027 SHALL discard a partially accumulated frame on mid-frame reset; first report after reset is the first complete frame after the first post-reset frame start.

Configuration
REQ-028 SHALL honour macro ISP_LUMA_STAT_WINDOW_EN: defined -> a pixel is accumulated only if win_x0<=col<=win_x1 and win_y0<=row<=win_y1; undefined -> every pixel accumulated, win_* ignored, ROI compare logic absent.
REQ-029 SHALL keep geometry check (REQ-023) and passthrough identical in both configurations.

Verification
REQ-030 Reset then 2 frames 1280x720 constant 100, thresh 16/235 -> second stat_done: stat_sum=92160000, stat_pix=921600, stat_lo=0, stat_hi=0, stat_err=0.
REQ-031 Frame alternating 10/250 per pixel, thresh 16/235 -> stat_lo=460800, stat_hi=460800, stat_sum=119808000.
REQ-032 Any video -> out_* equal to in_* delayed 1 cycle, every cycle; no stat_done before second post-reset frame start.
REQ-033 Frame with 719 lines, then frame with one 1279-pixel line -> stat_err=1 both reports; next good frame -> stat_err=0.
REQ-034 rst=1 asserted at line 300 of a frame -> all outputs 0 next cycle; first report covers only the next full frame.
REQ-035 With ISP_LUMA_STAT_WINDOW_EN, window 0..9 x 0..9, constant 200 -> stat_pix=100, stat_sum=20000.
